datapath_ctrl: RTL and testbench
================================

DATAPATH_CTRL -- requirements
Module: datapath_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, width of the register-file writeback path being sequenced.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 8, max cycles spent waiting for mem_ready in MEM.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port instr_valid  input  1  instruction offered.
REQ-006 SHALL have port instr_ready  output  1  controller accepts instruction this cycle.
REQ-007 SHALL have port opcode  input  3  instruction opcode, sampled on accept.
REQ-008 SHALL have port mem_ready  input  1  memory load data valid on the data bus.
REQ-009 SHALL have port mem_read  output  1  load request to memory.
REQ-010 SHALL have port alu_op  output  2  ALU function: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-011 SHALL have port mux_control  output  1  writeback select, 1 = memory data, 0 = ALU result.
REQ-012 SHALL have port reg_write  output  1  register-file write enable.
REQ-013 SHALL have port done  output  1  one-cycle pulse, instruction retired.
REQ-014 SHALL have port error  output  1  one-cycle pulse, illegal opcode or memory timeout.

Function
REQ-015 SHALL implement states IDLE, DECODE, EXEC, MEM, WB.
REQ-016 SHALL assert instr_ready only in IDLE; accept = instr_valid && instr_ready; opcode latched on accept; IDLE->DECODE on accept, else stay.
REQ-017 SHALL decode opcodes: 000 NOP, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 LOAD, 110/111 illegal.
REQ-018 DECODE SHALL go: ALU ops -> EXEC; LOAD -> MEM; NOP -> IDLE with done pulse; illegal -> IDLE with error pulse, no reg_write.
REQ-019 EXEC SHALL drive alu_op per opcode for one cycle, then go to WB.
REQ-020 MEM SHALL hold mem_read=1 until mem_ready=1, then go to WB; mem_ready outside MEM SHALL be ignored.
REQ-021 WB SHALL assert reg_write=1 for exactly one cycle with mux_control=1 for LOAD, 0 for ALU ops, pulse done, and return to IDLE.
REQ-022 ALU instruction latency SHALL be 4 cycles accept-to-done: accept(IDLE), DECODE, EXEC, WB.
REQ-023 LOAD latency SHALL be 3 + N cycles, N = MEM cycles up to and including the cycle mem_ready is seen (minimum 1).
REQ-024 alu_op SHALL hold its last decoded value outside EXEC; mux_control SHALL be 0 outside WB.
REQ-025 done and error SHALL never be asserted in the same cycle.
REQ-026 instr_valid while busy SHALL be ignored (not accepted, not queued).

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE from any state, including mid-MEM.
REQ-028 Reset values SHALL be instr_ready=1 (first cycle after reset), mem_read=0, alu_op=00, mux_control=0, reg_write=0, done=0, error=0, timeout counter=0.
REQ-029 A reset during MEM or WB SHALL suppress the pending reg_write and done.

Configuration
REQ-030 With DATAPATH_CTRL_TIMEOUT_EN defined, a counter SHALL count MEM cycles; on the MEM_TIMEOUT-th cycle without mem_ready the block SHALL pulse error, drop mem_read, and return to IDLE without reg_write; mem_ready in that same cycle wins (go to WB).
REQ-031 Without DATAPATH_CTRL_TIMEOUT_EN, MEM SHALL wait indefinitely and error SHALL pulse only for illegal opcodes.

Structure
REQ-032 Shared package datapath_pkg SHALL hold opcode constants, state enum typedef, and alu_op encodings.
REQ-033 Timeout counter SHALL be a sub-module mem_timeout_counter (clear, enable, expired), instantiated only under DATAPATH_CTRL_TIMEOUT_EN.

Verification
REQ-034 rst held 2 cycles then released -> instr_ready=1, all other outputs 0.
REQ-035 opcode=010 accepted at cycle 0 -> alu_op=01 at cycle 2, reg_write=1, mux_control=0, done=1 at cycle 3, instr_ready=1 at cycle 4.
REQ-036 opcode=101, mem_ready raised 3 cycles into MEM -> mem_read=1 for 3 cycles, then WB with mux_control=1, reg_write=1, done=1.
REQ-037 opcode=111 -> error pulse after DECODE, reg_write never asserted, back to IDLE.
REQ-038 With DATAPATH_CTRL_TIMEOUT_EN, MEM_TIMEOUT=8, LOAD with mem_ready never raised -> error pulse on 8th MEM cycle, no reg_write; without the macro -> mem_read stays 1 for 20+ cycles.
REQ-039 rst asserted during MEM with mem_ready=1 the same cycle -> IDLE next cycle, no reg_write, no done.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared opcode, ALU-function and controller-state definitions for datapath_ctrl.
package datapath_pkg;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_AND  = 3'b011;
   localparam logic [2:0] OP_OR   = 3'b100;
   localparam logic [2:0] OP_LOAD = 3'b101;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB
   } state_t;

   function automatic logic is_alu_op(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
   endfunction

   function automatic logic [1:0] alu_encode(input logic [2:0] op);
      logic [1:0] fn;
      fn = ALU_ADD;
      case (op)
         OP_SUB:  fn = ALU_SUB;
         OP_AND:  fn = ALU_AND;
         OP_OR:   fn = ALU_OR;
         default: fn = ALU_ADD;
      endcase
      return fn;
   endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts consecutive MEM cycles; expired_o flags the LIMIT-th cycle while enabled.
module mem_timeout_counter #(
   parameter int LIMIT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   assign expired_o = enable_i && (count_q == CW'(LIMIT - 1));

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && !expired_o) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/datapath_ctrl.sv
// Multi-cycle IDLE/DECODE/EXEC/MEM/WB sequencer with registered control outputs.
// DATAPATH_CTRL_TIMEOUT_EN bounds the MEM wait to MEM_TIMEOUT cycles and flags an error on expiry.
module datapath_ctrl
   import datapath_pkg::*;
#(
   parameter int DATA_WIDTH  = 4,
   parameter int MEM_TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       instr_valid,
   output logic       instr_ready,
   input  logic [2:0] opcode,
   input  logic       mem_ready,
   output logic       mem_read,
   output logic [1:0] alu_op,
   output logic       mux_control,
   output logic       reg_write,
   output logic       done,
   output logic       error
);

   if (DATA_WIDTH < 1 || MEM_TIMEOUT < 1) begin : g_bad_cfg
      $error("datapath_ctrl: DATA_WIDTH and MEM_TIMEOUT must both be at least 1");
   end

   state_t     state_q;
   logic [2:0] opcode_q;
   logic       instr_ready_q;
   logic       mem_read_q;
   logic [1:0] alu_op_q;
   logic       mux_control_q;
   logic       reg_write_q;
   logic       done_q;
   logic       error_q;
   logic       timeout_hit;

`ifdef DATAPATH_CTRL_TIMEOUT_EN
   mem_timeout_counter #(
      .LIMIT(MEM_TIMEOUT)
   ) u_mem_timeout (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (state_q != S_MEM),
      .enable_i (state_q == S_MEM),
      .expired_o(timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   // Outputs are registered alongside the state, so each one reflects the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         opcode_q      <= OP_NOP;
         instr_ready_q <= 1'b1;
         mem_read_q    <= 1'b0;
         alu_op_q      <= ALU_ADD;
         mux_control_q <= 1'b0;
         reg_write_q   <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
      end else begin
         mux_control_q <= 1'b0;
         reg_write_q   <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (instr_valid && instr_ready_q) begin
                  opcode_q      <= opcode;
                  instr_ready_q <= 1'b0;
                  state_q       <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (is_alu_op(opcode_q)) begin
                  alu_op_q <= alu_encode(opcode_q);
                  state_q  <= S_EXEC;
               end else if (opcode_q == OP_LOAD) begin
                  mem_read_q <= 1'b1;
                  state_q    <= S_MEM;
               end else if (opcode_q == OP_NOP) begin
                  done_q        <= 1'b1;
                  instr_ready_q <= 1'b1;
                  state_q       <= S_IDLE;
               end else begin
                  error_q       <= 1'b1;
                  instr_ready_q <= 1'b1;
                  state_q       <= S_IDLE;
               end
            end
            S_EXEC: begin
               reg_write_q <= 1'b1;
               done_q      <= 1'b1;
               state_q     <= S_WB;
            end
            S_MEM: begin
               // Data arriving on the last allowed cycle still completes the load.
               if (mem_ready) begin
                  mem_read_q    <= 1'b0;
                  reg_write_q   <= 1'b1;
                  mux_control_q <= 1'b1;
                  done_q        <= 1'b1;
                  state_q       <= S_WB;
               end else if (timeout_hit) begin
                  mem_read_q    <= 1'b0;
                  error_q       <= 1'b1;
                  instr_ready_q <= 1'b1;
                  state_q       <= S_IDLE;
               end
            end
            S_WB: begin
               instr_ready_q <= 1'b1;
               state_q       <= S_IDLE;
            end
            default: begin
               instr_ready_q <= 1'b1;
               mem_read_q    <= 1'b0;
               state_q       <= S_IDLE;
            end
         endcase
      end
   end

   assign instr_ready = instr_ready_q;
   assign mem_read    = mem_read_q;
   assign alu_op      = alu_op_q;
   assign mux_control = mux_control_q;
   assign reg_write   = reg_write_q;
   assign done        = done_q;
   assign error       = error_q;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl: directed vector table, reset corner sequences, randomized run vs. timing model.
module tb_datapath_ctrl;

   localparam int DW  = 4;
   localparam int TO  = 8;
   localparam int BIG = 1 << 30;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       instr_valid = 1'b0;
   logic [2:0] opcode = 3'b000;
   logic       mem_ready = 1'b0;
   logic       instr_ready;
   logic       mem_read;
   logic [1:0] alu_op;
   logic       mux_control;
   logic       reg_write;
   logic       done;
   logic       error;

   int n_cmp = 0;
   int n_bad = 0;

   datapath_ctrl #(
      .DATA_WIDTH (DW),
      .MEM_TIMEOUT(TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .opcode     (opcode),
      .mem_ready  (mem_ready),
      .mem_read   (mem_read),
      .alu_op     (alu_op),
      .mux_control(mux_control),
      .reg_write  (reg_write),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] op;
      int         n;       // MEM cycle on which mem_ready is raised (0 = never)
      int         done_k;  // cycle offset from accept, -1 = never
      int         err_k;
      int         rdy_k;
      int         rw;
      int         mrd;
      logic [1:0] alu2;
      logic       mux;
   } vec_t;

   vec_t tbl[12];

   // Random-phase reference model: event cycles derived from the documented latencies.
   int ready_cyc, wb_cyc, done_cyc, err_cyc, mem_start, mem_end, alu_cyc;
   int alu_old, alu_new, e_alu, wb_mux, is_load, mem_open;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   function automatic int alu_code(input int op);
      case (op)
         1:       return 0;
         2:       return 1;
         3:       return 2;
         4:       return 3;
         default: return -1;
      endcase
   endfunction

   task automatic run_instr(input logic [2:0] op, input int n,
                            output int done_k, output int err_k, output int rdy_k,
                            output int rw, output int mrd, output int alu2,
                            output int mux_any, output int both);
      done_k = -1; err_k = -1; rdy_k = -1;
      rw = 0; mrd = 0; alu2 = -1; mux_any = 0; both = 0;
      instr_valid = 1'b1;
      opcode      = op;
      mem_ready   = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         tick();
         instr_valid = 1'b0;
         if (mem_read) mrd++;
         mem_ready = mem_read && (mrd == n);
         if (reg_write) rw++;
         if (mux_control) mux_any = 1;
         if (done && done_k < 0) done_k = k;
         if (error && err_k < 0) err_k = k;
         if (done && error) both++;
         if (k == 2) alu2 = int'(alu_op);
         if (instr_ready) begin
            rdy_k = k;
            break;
         end
      end
      mem_ready = 1'b0;
   endtask

   task automatic check_instr(input string tag, input vec_t v);
      int d, e, r, w, m, a, x, b;
      run_instr(v.op, v.n, d, e, r, w, m, a, x, b);
      chk({tag, " done_k"}, d, v.done_k);
      chk({tag, " err_k"}, e, v.err_k);
      chk({tag, " ready_k"}, r, v.rdy_k);
      chk({tag, " reg_write_cnt"}, w, v.rw);
      chk({tag, " mem_read_cnt"}, m, v.mrd);
      chk({tag, " alu_op@2"}, a, int'(v.alu2));
      chk({tag, " mux_seen"}, x, int'(v.mux));
      chk({tag, " done&error"}, b, 0);
   endtask

   initial begin
      vec_t tv;
      int   iv, op, mr;

      tbl[0]  = '{3'b010, 0,  3, -1,  4, 1, 0, 2'b01, 1'b0};
      tbl[1]  = '{3'b001, 0,  3, -1,  4, 1, 0, 2'b00, 1'b0};
      tbl[2]  = '{3'b011, 0,  3, -1,  4, 1, 0, 2'b10, 1'b0};
      tbl[3]  = '{3'b100, 0,  3, -1,  4, 1, 0, 2'b11, 1'b0};
      tbl[4]  = '{3'b101, 3,  5, -1,  6, 1, 3, 2'b11, 1'b1};
      tbl[5]  = '{3'b101, 1,  3, -1,  4, 1, 1, 2'b11, 1'b1};
      tbl[6]  = '{3'b000, 0,  2, -1,  2, 0, 0, 2'b11, 1'b0};
      tbl[7]  = '{3'b111, 0, -1,  2,  2, 0, 0, 2'b11, 1'b0};
      tbl[8]  = '{3'b110, 0, -1,  2,  2, 0, 0, 2'b11, 1'b0};
      tbl[9]  = '{3'b001, 0,  3, -1,  4, 1, 0, 2'b00, 1'b0};
      tbl[10] = '{3'b101, 7,  9, -1, 10, 1, 7, 2'b00, 1'b1};
      tbl[11] = '{3'b101, 8, 10, -1, 11, 1, 8, 2'b00, 1'b1};

      // Reset held two cycles, then released.
      tick();
      tick();
      rst = 1'b0;
      chk("reset instr_ready", int'(instr_ready), 1);
      chk("reset mem_read", int'(mem_read), 0);
      chk("reset alu_op", int'(alu_op), 0);
      chk("reset mux_control", int'(mux_control), 0);
      chk("reset reg_write", int'(reg_write), 0);
      chk("reset done", int'(done), 0);
      chk("reset error", int'(error), 0);

      foreach (tbl[i]) check_instr($sformatf("vec%0d", i), tbl[i]);

`ifdef DATAPATH_CTRL_TIMEOUT_EN
      tv = '{3'b101, 0, -1, 2 + TO, 2 + TO, 0, TO, 2'b00, 1'b0};
`else
      tv = '{3'b101, 25, 27, -1, 28, 1, 25, 2'b00, 1'b1};
`endif
      check_instr("load_wait", tv);

      // Reset in MEM with mem_ready high on the same edge.
      instr_valid = 1'b1;
      opcode      = 3'b101;
      tick();
      instr_valid = 1'b0;
      tick();
      chk("rstmem mem_read", int'(mem_read), 1);
      tick();
      rst       = 1'b1;
      mem_ready = 1'b1;
      tick();
      chk("rstmem instr_ready", int'(instr_ready), 1);
      chk("rstmem mem_read", int'(mem_read), 0);
      chk("rstmem reg_write", int'(reg_write), 0);
      chk("rstmem done", int'(done), 0);
      chk("rstmem error", int'(error), 0);
      rst       = 1'b0;
      mem_ready = 1'b0;
      tick();
      chk("rstmem later reg_write", int'(reg_write), 0);
      chk("rstmem later done", int'(done), 0);

      // Reset in EXEC: the write-back never happens.
      instr_valid = 1'b1;
      opcode      = 3'b010;
      tick();
      instr_valid = 1'b0;
      tick();
      chk("rstexec alu_op", int'(alu_op), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstexec reg_write", int'(reg_write), 0);
      chk("rstexec done", int'(done), 0);
      chk("rstexec alu_op", int'(alu_op), 0);
      tick();
      chk("rstexec later reg_write", int'(reg_write), 0);
      chk("rstexec later instr_ready", int'(instr_ready), 1);

      // Randomized traffic, including offers while busy and stray mem_ready.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ready_cyc = 0; wb_cyc = -1; done_cyc = -1; err_cyc = -1;
      mem_start = BIG; mem_end = BIG; alu_cyc = 0;
      alu_old = 0; alu_new = 0; wb_mux = 0; is_load = 0; mem_open = 0;
      for (int c = 0; c < 1500; c++) begin
         e_alu = (c >= alu_cyc) ? alu_new : alu_old;
         chk("rnd instr_ready", int'(instr_ready), int'(c >= ready_cyc));
         chk("rnd mem_read", int'(mem_read), int'(is_load != 0 && c >= mem_start && c < mem_end));
         chk("rnd alu_op", int'(alu_op), e_alu);
         chk("rnd reg_write", int'(reg_write), int'(c == wb_cyc));
         chk("rnd mux_control", int'(mux_control), int'(c == wb_cyc && wb_mux != 0));
         chk("rnd done", int'(done), int'(c == done_cyc));
         chk("rnd error", int'(error), int'(c == err_cyc));

         iv = ($urandom_range(0, 2) != 0) ? 1 : 0;
         op = int'($urandom_range(0, 9));
         if (op > 7) op = 5;
         mr = ($urandom_range(0, 3) == 0) ? 1 : 0;
         instr_valid = (iv != 0);
         opcode      = 3'(op);
         mem_ready   = (mr != 0);

         if (c >= ready_cyc && iv != 0) begin
            is_load = 0;
            case (op)
               0: begin
                  done_cyc  = c + 2;
                  ready_cyc = c + 2;
               end
               1, 2, 3, 4: begin
                  alu_old   = e_alu;
                  alu_new   = alu_code(op);
                  alu_cyc   = c + 2;
                  wb_cyc    = c + 3;
                  done_cyc  = c + 3;
                  wb_mux    = 0;
                  ready_cyc = c + 4;
               end
               5: begin
                  is_load   = 1;
                  mem_open  = 1;
                  mem_start = c + 2;
                  mem_end   = BIG;
                  ready_cyc = BIG;
               end
               default: begin
                  err_cyc   = c + 2;
                  ready_cyc = c + 2;
               end
            endcase
         end else if (mem_open != 0 && c >= mem_start) begin
            if (mr != 0) begin
               wb_cyc    = c + 1;
               done_cyc  = c + 1;
               wb_mux    = 1;
               mem_end   = c + 1;
               ready_cyc = c + 2;
               mem_open  = 0;
`ifdef DATAPATH_CTRL_TIMEOUT_EN
            end else if (c - mem_start + 1 == TO) begin
               err_cyc   = c + 1;
               mem_end   = c + 1;
               ready_cyc = c + 1;
               mem_open  = 0;
`endif
            end
         end
         tick();
      end
      instr_valid = 1'b0;
      mem_ready   = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
